display_select_ctrl: RTL and testbench

Upstream controller for the hex-display debug mux. It turns raw board pushbuttons and switches into the 5-bit `Display_Select` and 1-bit `Display_Enable` that the mux consumes, so that 8-digit HEX output can be stepped through debug views (Stage, PC, IR, CCR, RA–RY, …) without recompiling. It provides debounced up/down stepping with wrap-around, a blank toggle, a direct switch-select mode and an optional timed auto-cycle mode.

---
 rtl/display_pkg.sv | 28 ++
 rtl/key_debounce.sv | 58 +++++
 rtl/display_select_ctrl.sv | 172 +++++++++++++++++
 tb/tb_display_select_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared definitions for the hex-display debug mux and its select controller.
//   SELECT_W        - width of the mux view index
//   NUM_DEBUG_VIEWS - number of views the mux decodes
//   mode_e          - select-controller operating mode
//   sel_inc/sel_dec - wrap-around stepping against an arbitrary top value
package display_pkg;

    localparam int unsigned SELECT_W        = 5;
    localparam int unsigned NUM_DEBUG_VIEWS = 20;

    typedef enum logic [1:0] {
        ModeManual,
        ModeDirect,
        ModeAuto
    } mode_e;

    // Wrap compares against the last valid view, not a power of two.
    function automatic logic [SELECT_W-1:0] sel_inc(input logic [SELECT_W-1:0] sel,
                                                    input logic [SELECT_W-1:0] max_sel);
        return (sel == max_sel) ? '0 : sel + 1'b1;
    endfunction

    function automatic logic [SELECT_W-1:0] sel_dec(input logic [SELECT_W-1:0] sel,
                                                    input logic [SELECT_W-1:0] max_sel);
        return (sel == '0) ? max_sel : sel - 1'b1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronise and debounce one active-low pushbutton.
//   Clock   - system clock
//   Reset_n - asynchronous active-low reset
//   key_n   - raw active-low key, asynchronous to Clock
//   level   - debounced key level (1 = released)
//   press   - one-cycle pulse on a debounced high-to-low transition
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_armed;

    // The synchroniser resets to "held" and presses are only armed once the key has been
    // seen released, so a key held through reset release never produces a press.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_press <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_armed <= r_armed | r_sync2;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                // Sample differs from level, so a high level here means a falling edge.
                r_press <= r_level & r_armed;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/display_select_ctrl.sv
// display_select_ctrl: turns board keys and switches into the debug-mux view select.
//   Clock, Reset_n            - system clock, asynchronous active-low reset
//   Key_Up_n, Key_Down_n      - raw active-low step keys
//   Key_Blank_n               - raw active-low key toggling blanking
//   Sw_Direct, Sw_DirectMode  - direct view value and direct-mode enable
//   Sw_Auto                   - auto-cycle request (only with DISPLAY_AUTOCYCLE_EN)
//   Display_Select            - registered view index
//   Display_Enable            - registered blank control (1 = blank)
//   Select_Changed            - one-cycle pulse when Display_Select changes
// Build option: define DISPLAY_AUTOCYCLE_EN to include the timed auto-cycle mode.
module display_select_ctrl
    import display_pkg::*;
#(
    parameter int unsigned NUM_SELECTS        = NUM_DEBUG_VIEWS,
    parameter int unsigned DEBOUNCE_CYCLES    = 500000,
    parameter int unsigned AUTO_PERIOD_CYCLES = 50000000
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                Key_Up_n,
    input  logic                Key_Down_n,
    input  logic                Key_Blank_n,
    input  logic [SELECT_W-1:0] Sw_Direct,
    input  logic                Sw_DirectMode,
    input  logic                Sw_Auto,
    output logic [SELECT_W-1:0] Display_Select,
    output logic                Display_Enable,
    output logic                Select_Changed
);

    localparam logic [SELECT_W-1:0] MAX_SEL = SELECT_W'(NUM_SELECTS - 1);

    logic                w_up_press;
    logic                w_down_press;
    logic                w_blank_press;
    logic [2:0]          w_unused_levels;
    logic [SELECT_W-1:0] r_dsync1;
    logic [SELECT_W-1:0] r_dsync2;
    logic                r_msync1;
    logic                r_msync2;
    logic [SELECT_W-1:0] w_clamped;
    logic [SELECT_W-1:0] w_manual_nxt;
    logic [SELECT_W-1:0] w_sel_nxt;
    logic [SELECT_W-1:0] r_sel;
    logic                r_blank;
    logic                r_changed;
    mode_e               w_mode;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .key_n   (Key_Up_n),
        .level   (w_unused_levels[0]),
        .press   (w_up_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_down (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .key_n   (Key_Down_n),
        .level   (w_unused_levels[1]),
        .press   (w_down_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_blank (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .key_n   (Key_Blank_n),
        .level   (w_unused_levels[2]),
        .press   (w_blank_press)
    );

`ifdef DISPLAY_AUTOCYCLE_EN
    localparam int unsigned DWELL_W =
        (AUTO_PERIOD_CYCLES > 1) ? $clog2(AUTO_PERIOD_CYCLES) : 1;
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(AUTO_PERIOD_CYCLES - 1);

    logic               r_async1;
    logic               r_async2;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] w_dwell_nxt;
`else
    logic        w_unused_auto;
    logic [31:0] w_unused_period;
    assign w_unused_auto   = Sw_Auto;
    assign w_unused_period = AUTO_PERIOD_CYCLES;
`endif

    // Mode is decoded every cycle from the synchronised switches; direct wins.
    always_comb begin
        w_mode = ModeManual;
        if (r_msync2) begin
            w_mode = ModeDirect;
`ifdef DISPLAY_AUTOCYCLE_EN
        end else if (r_async2) begin
            w_mode = ModeAuto;
`endif
        end
    end

    assign w_clamped = (r_dsync2 > MAX_SEL) ? MAX_SEL : r_dsync2;

    // Simultaneous up and down cancel.
    always_comb begin
        w_manual_nxt = r_sel;
        if (w_up_press && !w_down_press) begin
            w_manual_nxt = sel_inc(r_sel, MAX_SEL);
        end else if (w_down_press && !w_up_press) begin
            w_manual_nxt = sel_dec(r_sel, MAX_SEL);
        end
    end

    always_comb begin
        w_sel_nxt = r_sel;
`ifdef DISPLAY_AUTOCYCLE_EN
        // Dwell stays cleared outside AUTO so each entry starts a full period.
        w_dwell_nxt = '0;
`endif
        case (w_mode)
            ModeDirect: w_sel_nxt = w_clamped;
`ifdef DISPLAY_AUTOCYCLE_EN
            ModeAuto: begin
                if (w_up_press || w_down_press) begin
                    w_sel_nxt = w_manual_nxt;
                end else if (r_dwell == DWELL_MAX) begin
                    w_sel_nxt = sel_inc(r_sel, MAX_SEL);
                end else begin
                    w_dwell_nxt = r_dwell + 1'b1;
                end
            end
`endif
            default: w_sel_nxt = w_manual_nxt;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_dsync1  <= '0;
            r_dsync2  <= '0;
            r_msync1  <= 1'b0;
            r_msync2  <= 1'b0;
            r_sel     <= '0;
            r_blank   <= 1'b0;
            r_changed <= 1'b0;
`ifdef DISPLAY_AUTOCYCLE_EN
            r_async1  <= 1'b0;
            r_async2  <= 1'b0;
            r_dwell   <= '0;
`endif
        end else begin
            r_dsync1  <= Sw_Direct;
            r_dsync2  <= r_dsync1;
            r_msync1  <= Sw_DirectMode;
            r_msync2  <= r_msync1;
            r_sel     <= w_sel_nxt;
            r_changed <= (w_sel_nxt != r_sel);
            if (w_blank_press) begin
                r_blank <= ~r_blank;
            end
`ifdef DISPLAY_AUTOCYCLE_EN
            r_async1  <= Sw_Auto;
            r_async2  <= r_async1;
            r_dwell   <= w_dwell_nxt;
`endif
        end
    end

    assign Display_Select = r_sel;
    assign Display_Enable = r_blank;
    assign Select_Changed = r_changed;

endmodule

// File: tb/tb_display_select_ctrl.sv
// tb_display_select_ctrl: randomized self-checking bench for display_select_ctrl.
// Expected views come from modular arithmetic on a model index, not from the RTL structure.
module tb_display_select_ctrl;

    localparam int unsigned N   = 20;
    localparam int unsigned DEB = 4;
    localparam int unsigned PER = 8;

    logic       Clock = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Key_Up_n = 1'b1;
    logic       Key_Down_n = 1'b1;
    logic       Key_Blank_n = 1'b1;
    logic [4:0] Sw_Direct = '0;
    logic       Sw_DirectMode = 1'b0;
    logic       Sw_Auto = 1'b0;
    logic [4:0] Display_Select;
    logic       Display_Enable;
    logic       Select_Changed;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    int model_sel = 0;
    logic model_en = 1'b0;

    display_select_ctrl #(
        .NUM_SELECTS        (N),
        .DEBOUNCE_CYCLES    (DEB),
        .AUTO_PERIOD_CYCLES (PER)
    ) dut (
        .Clock          (Clock),
        .Reset_n        (Reset_n),
        .Key_Up_n       (Key_Up_n),
        .Key_Down_n     (Key_Down_n),
        .Key_Blank_n    (Key_Blank_n),
        .Sw_Direct      (Sw_Direct),
        .Sw_DirectMode  (Sw_DirectMode),
        .Sw_Auto        (Sw_Auto),
        .Display_Select (Display_Select),
        .Display_Enable (Display_Enable),
        .Select_Changed (Select_Changed)
    );

    always #5 Clock = ~Clock;

    // Advance n cycles, sampling on the falling edge and counting change pulses.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge Clock);
            if (Select_Changed) pulses++;
        end
    endtask

    // which: 0 up, 1 down, 2 blank, 3 up+down together.
    task automatic do_key(input int which, input int hold);
        if (which == 0 || which == 3) Key_Up_n = 1'b0;
        if (which == 1 || which == 3) Key_Down_n = 1'b0;
        if (which == 2) Key_Blank_n = 1'b0;
        step(hold);
        Key_Up_n = 1'b1;
        Key_Down_n = 1'b1;
        Key_Blank_n = 1'b1;
        step(10);
    endtask

    task automatic test_reset;
        Reset_n = 1'b0;
        step(2);
        checks++;
        if (Display_Select !== 5'd0 || Display_Enable !== 1'b0 || Select_Changed !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: sel=%0d en=%0b chg=%0b required 0/0/0",
                     Display_Select, Display_Enable, Select_Changed);
        end
        Reset_n = 1'b1;
        step(4);
    endtask

    task automatic test_latency;
        int first;
        first = -1;
        pulses = 0;
        Key_Up_n = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge Clock);
            if (Select_Changed) pulses++;
            if (first < 0 && Display_Select != 5'(model_sel)) first = c;
            if (c == 10) Key_Up_n = 1'b1;
        end
        model_sel = (model_sel + 1) % N;
        checks++;
        if (first != 7) begin
            failures++;
            $display("FAIL press_latency: changed after %0d cycles, required 7", first);
        end
        checks++;
        if (Display_Select !== 5'(model_sel)) begin
            failures++;
            $display("FAIL first_up: sel=%0d required %0d", Display_Select, model_sel);
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL first_up_pulse: pulses=%0d required 1", pulses);
        end
    endtask

    task automatic test_wrap;
        int fixed_dir [3] = '{1, 1, 0};
        int dir;
        for (int i = 0; i < 15; i++) begin
            dir = (i < 3) ? fixed_dir[i] : int'($urandom_range(0, 1));
            pulses = 0;
            do_key(dir, int'($urandom_range(DEB, DEB + 5)));
            model_sel = (dir == 0) ? (model_sel + 1) % N : (model_sel + N - 1) % N;
            checks++;
            if (Display_Select !== 5'(model_sel)) begin
                failures++;
                $display("FAIL step_%0d dir=%0d: sel=%0d required %0d", i, dir,
                         Display_Select, model_sel);
            end
            checks++;
            if (pulses != 1) begin
                failures++;
                $display("FAIL step_pulse_%0d: pulses=%0d required 1", i, pulses);
            end
        end
    endtask

    task automatic test_bounce;
        int key;
        pulses = 0;
        for (int r = 0; r < 2; r++) begin
            key = int'($urandom_range(0, 1));
            if (key == 0) Key_Up_n = 1'b0; else Key_Down_n = 1'b0;
            step(3);
            Key_Up_n = 1'b1; Key_Down_n = 1'b1;
            step(1);
            if (key == 0) Key_Up_n = 1'b0; else Key_Down_n = 1'b0;
            step(3);
            Key_Up_n = 1'b1; Key_Down_n = 1'b1;
            step(10);
        end
        checks++;
        if (Display_Select !== 5'(model_sel) || pulses != 0) begin
            failures++;
            $display("FAIL bounce: sel=%0d pulses=%0d required %0d and 0", Display_Select,
                     pulses, model_sel);
        end
        pulses = 0;
        do_key(3, int'($urandom_range(DEB, DEB + 4)));
        checks++;
        if (Display_Select !== 5'(model_sel) || pulses != 0) begin
            failures++;
            $display("FAIL up_down_cancel: sel=%0d pulses=%0d required %0d and 0",
                     Display_Select, pulses, model_sel);
        end
    endtask

    task automatic test_direct;
        int v;
        int exp_sel;
        Sw_DirectMode = 1'b1;
        Sw_Direct = 5'd25;
        step(2);
        checks++;
        if (Display_Select !== 5'(model_sel)) begin
            failures++;
            $display("FAIL direct_early: sel=%0d required %0d", Display_Select, model_sel);
        end
        step(1);
        model_sel = N - 1;
        checks++;
        if (Display_Select !== 5'(model_sel)) begin
            failures++;
            $display("FAIL direct_clamp: sel=%0d required %0d", Display_Select, model_sel);
        end
        for (int i = 0; i < 5; i++) begin
            v = int'($urandom_range(0, 31));
            Sw_Direct = 5'(v);
            step(3);
            exp_sel = (v > N - 1) ? N - 1 : v;
            model_sel = exp_sel;
            checks++;
            if (Display_Select !== 5'(exp_sel)) begin
                failures++;
                $display("FAIL direct_track_%0d sw=%0d: sel=%0d required %0d", i, v,
                         Display_Select, exp_sel);
            end
        end
        pulses = 0;
        do_key(0, 6);
        checks++;
        if (Display_Select !== 5'(model_sel) || pulses != 0) begin
            failures++;
            $display("FAIL direct_ignores_up: sel=%0d pulses=%0d required %0d and 0",
                     Display_Select, pulses, model_sel);
        end
        Sw_Direct = 5'd25;
        step(3);
        model_sel = N - 1;
        Sw_DirectMode = 1'b0;
        Sw_Direct = 5'($urandom_range(0, 31));
        step(3);
        checks++;
        if (Display_Select !== 5'(model_sel)) begin
            failures++;
            $display("FAIL leave_direct: sel=%0d required %0d", Display_Select, model_sel);
        end
        pulses = 0;
        do_key(0, 5);
        model_sel = (model_sel + 1) % N;
        checks++;
        if (Display_Select !== 5'(model_sel) || pulses != 1) begin
            failures++;
            $display("FAIL up_after_direct: sel=%0d pulses=%0d required %0d and 1",
                     Display_Select, pulses, model_sel);
        end
    endtask

`ifdef DISPLAY_AUTOCYCLE_EN
    task automatic test_auto;
        int gap;
        Sw_Auto = 1'b1;
        for (int a = 0; a < 21; a++) begin
            gap = 0;
            do begin
                @(negedge Clock);
                gap++;
            end while (!Select_Changed && gap < 30);
            model_sel = (model_sel + 1) % N;
            checks++;
            if (Display_Select !== 5'(model_sel) || !Select_Changed) begin
                failures++;
                $display("FAIL auto_value_%0d: sel=%0d required %0d", a, Display_Select,
                         model_sel);
            end
            if (a > 0) begin
                checks++;
                if (gap != PER) begin
                    failures++;
                    $display("FAIL auto_period_%0d: gap=%0d required %0d", a, gap, PER);
                end
            end
        end
        Key_Down_n = 1'b0;
        gap = 0;
        do begin
            @(negedge Clock);
            gap++;
            if (gap == 5) Key_Down_n = 1'b1;
        end while (!Select_Changed && gap < 30);
        Key_Down_n = 1'b1;
        model_sel = (model_sel + N - 1) % N;
        checks++;
        if (gap != 7 || Display_Select !== 5'(model_sel)) begin
            failures++;
            $display("FAIL auto_down: gap=%0d sel=%0d required 7 and %0d", gap,
                     Display_Select, model_sel);
        end
        gap = 0;
        do begin
            @(negedge Clock);
            gap++;
        end while (!Select_Changed && gap < 30);
        model_sel = (model_sel + 1) % N;
        checks++;
        if (gap != PER || Display_Select !== 5'(model_sel)) begin
            failures++;
            $display("FAIL auto_restart: gap=%0d sel=%0d required %0d and %0d", gap,
                     Display_Select, PER, model_sel);
        end
        Sw_Auto = 1'b0;
        pulses = 0;
        step(20);
        checks++;
        if (Display_Select !== 5'(model_sel) || pulses != 0) begin
            failures++;
            $display("FAIL auto_exit: sel=%0d pulses=%0d required %0d and 0",
                     Display_Select, pulses, model_sel);
        end
    endtask
`else
    task automatic test_auto;
        Sw_Auto = 1'b1;
        pulses = 0;
        step(30);
        checks++;
        if (Display_Select !== 5'(model_sel) || pulses != 0) begin
            failures++;
            $display("FAIL auto_ignored: sel=%0d pulses=%0d required %0d and 0",
                     Display_Select, pulses, model_sel);
        end
        Sw_Auto = 1'b0;
        step(3);
    endtask
`endif

    task automatic test_blank;
        for (int i = 0; i < 2; i++) begin
            pulses = 0;
            do_key(2, int'($urandom_range(DEB, DEB + 4)));
            model_en = ~model_en;
            checks++;
            if (Display_Enable !== model_en) begin
                failures++;
                $display("FAIL blank_toggle_%0d: en=%0b required %0b", i, Display_Enable,
                         model_en);
            end
            checks++;
            if (Display_Select !== 5'(model_sel) || pulses != 0) begin
                failures++;
                $display("FAIL blank_keeps_sel_%0d: sel=%0d pulses=%0d required %0d and 0",
                         i, Display_Select, pulses, model_sel);
            end
        end
    endtask

    task automatic test_reset_mid;
        do_key(2, 5);
        if (model_sel == 0) do_key(0, 5);
        Key_Up_n = 1'b0;
        step(4);
        Reset_n = 1'b0;
        #1;
        checks++;
        if (Display_Select !== 5'd0 || Display_Enable !== 1'b0 || Select_Changed !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: sel=%0d en=%0b chg=%0b required 0/0/0",
                     Display_Select, Display_Enable, Select_Changed);
        end
        @(negedge Clock);
        Reset_n = 1'b1;
        model_sel = 0;
        model_en = 1'b0;
        pulses = 0;
        step(15);
        checks++;
        if (Display_Select !== 5'd0 || pulses != 0) begin
            failures++;
            $display("FAIL held_through_reset: sel=%0d pulses=%0d required 0 and 0",
                     Display_Select, pulses);
        end
        Key_Up_n = 1'b1;
        step(10);
        do_key(0, 6);
        model_sel = (model_sel + 1) % N;
        checks++;
        if (Display_Select !== 5'(model_sel)) begin
            failures++;
            $display("FAIL up_after_reset: sel=%0d required %0d", Display_Select, model_sel);
        end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_wrap;
        test_bounce;
        test_direct;
        test_auto;
        test_blank;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
